// File: rtl/fdd_track_emu_if.sv
// SD-card side of the floppy track emulator: per-drive read/write requests,
// LBA, completion handshake and the byte port into the sector buffer.
interface fdd_track_emu_if #(
  parameter int NDRIVES = 4,
  parameter int WORDS   = 256
);
  logic [NDRIVES-1:0]           rstart;
  logic [NDRIVES-1:0]           wstart;
  logic [31:0]                  rsector;
  logic                         sd_busy;
  logic                         sd_done;
  logic                         outen;
  logic [$clog2(2*WORDS)-1:0]   outaddr;
  logic [7:0]                   inbyte;
  logic [7:0]                   outbyte;

  modport master (output rstart, wstart, rsector, outbyte,
                  input  sd_busy, sd_done, outen, outaddr, inbyte);
  modport slave  (input  rstart, wstart, rsector, outbyte,
                  output sd_busy, sd_done, outen, outaddr, inbyte);
endinterface

// File: rtl/fdd_track_emu.sv
// Parametrised floppy track emulator: rotation timing, raw word stream, SD
// sector fetch and write-back. Define FDD_WPROT_EN for per-drive write protect.
module fdd_track_emu #(
  parameter int CLK_DIV = 1600,
  parameter int NDRIVES = 4,
  parameter int TRACKS  = 80,
  parameter int HEADS   = 2,
  parameter int SECTORS = 10,
  parameter int WORDS   = 256,
  parameter int GAP1    = 24,
  parameter int GAP2    = 19,
  parameter int GAP3    = 2,
  parameter int GAP4    = 54
) (
  input  logic                       pin_25mhz_ck,
  input  logic                       ppu_vm_init_n,
  input  logic [$clog2(NDRIVES)-1:0] drive,
  input  logic                       motor,
  input  logic                       step,
  input  logic                       dir,
  input  logic                       head,
  input  logic                       write,
  input  logic [15:0]                data_in,
  input  logic [NDRIVES-1:0]         mount_dsk,
  output logic [15:0]                data_out,
  output logic                       valid,
  output logic                       sync,
  output logic                       crc_ok,
  output logic                       ind,
  output logic                       tr0,
  output logic                       rdy,
`ifdef FDD_WPROT_EN
  input  logic [NDRIVES-1:0]         wprot,
  output logic                       wp,
`endif
  fdd_track_emu_if.master            sd
);
  localparam int S      = GAP1 + 4 + GAP2 + 1 + WORDS + 1 + GAP3;
  localparam int D_SYNC = GAP1 + 4 + GAP2;
  localparam int D0     = D_SYNC + 1;
  localparam int D_CRC  = D0 + WORDS;
  localparam int PW     = $clog2(CLK_DIV);
  localparam int SLW    = $clog2((S > GAP4) ? S : GAP4);
  localparam int SCW    = $clog2(SECTORS + 1);
  localparam int TW     = $clog2(TRACKS);
  localparam int WW     = $clog2(WORDS);
  localparam int DW     = $clog2(NDRIVES);
  localparam logic [15:0] GAP_W = 16'h4E4E;

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT} st_t;

  logic [PW-1:0]              presc;
  logic [SLW-1:0]             slot;
  logic [SCW-1:0]             sector;   // SECTORS = end-of-track gap
  logic [NDRIVES-1:0][TW-1:0] track;
  logic [2:0]                 step_s;
  logic                       head_q;
  logic [DW-1:0]              drive_q, req_drive;
  logic [15:0]                mem [WORDS];
  st_t                        st;
  logic                       buf_valid, dirty, data_ok;

  logic [TW-1:0] cur_track;
  logic [WW-1:0] widx, baddr;
  logic [31:0]   lba;
  logic en, mounted, first, step_rise, restart, in_sec, last_slot;
  logic is_hsync, is_hw1, is_hw2, is_hcrc, is_dsync, is_data, is_dcrc, is_g3;
  logic wp_blk, wr_ok;

  assign cur_track = track[drive];
  assign mounted   = mount_dsk[drive];
  assign en        = rdy & motor;
  assign first     = (presc == '0);
  assign step_rise = step_s[1] & ~step_s[2];
  assign restart   = !motor | step_rise | (head != head_q) | (drive != drive_q);
  assign in_sec    = (sector < SCW'(SECTORS));
  assign last_slot = in_sec ? (slot == SLW'(S - 1)) : (slot == SLW'(GAP4 - 1));
  assign is_hsync  = in_sec && slot == SLW'(GAP1);
  assign is_hw1    = in_sec && slot == SLW'(GAP1 + 1);
  assign is_hw2    = in_sec && slot == SLW'(GAP1 + 2);
  assign is_hcrc   = in_sec && slot == SLW'(GAP1 + 3);
  assign is_dsync  = in_sec && slot == SLW'(D_SYNC);
  assign is_data   = in_sec && slot >= SLW'(D0) && slot < SLW'(D_CRC);
  assign is_dcrc   = in_sec && slot == SLW'(D_CRC);
  assign is_g3     = in_sec && slot == SLW'(D_CRC + 1);
  assign widx      = WW'(slot - SLW'(D0));
  assign baddr     = sd.outaddr[WW:1];
  assign lba       = (32'(cur_track) * HEADS + 32'(head)) * SECTORS + 32'(sector);

`ifdef FDD_WPROT_EN
  assign wp_blk = wprot[drive];
  assign wp     = en & wprot[drive];
`else
  assign wp_blk = 1'b0;
`endif

  assign wr_ok = en && is_data && write && buf_valid && mounted && !wp_blk;

  // Rotation, stepping and the restart rules share one register block
  always_ff @(posedge pin_25mhz_ck or negedge ppu_vm_init_n) begin
    if (!ppu_vm_init_n) begin
      presc <= '0; slot <= '0; sector <= '0; track <= '0;
      step_s <= '0; head_q <= 1'b0; drive_q <= '0; rdy <= 1'b0;
    end else begin
      rdy    <= 1'b1;
      step_s <= {step_s[1:0], step};
      head_q <= head;
      drive_q <= drive;
      if (step_rise) begin
        if (dir && cur_track != TW'(TRACKS - 1)) track[drive] <= cur_track + 1'b1;
        else if (!dir && cur_track != '0)        track[drive] <= cur_track - 1'b1;
      end
      if (restart) begin
        presc <= '0; slot <= '0; sector <= '0;
      end else if (presc == PW'(CLK_DIV - 1)) begin
        presc <= '0;
        if (last_slot) begin
          slot   <= '0;
          sector <= in_sec ? sector + 1'b1 : '0;
        end else begin
          slot <= slot + 1'b1;
        end
      end else begin
        presc <= presc + 1'b1;
      end
    end
  end

  always_ff @(posedge pin_25mhz_ck or negedge ppu_vm_init_n) begin
    if (!ppu_vm_init_n) begin
      st <= IDLE; buf_valid <= 1'b0; dirty <= 1'b0; data_ok <= 1'b0;
      req_drive <= '0;
      sd.rstart <= '0; sd.wstart <= '0; sd.rsector <= '0;
    end else begin
      if (is_dsync) data_ok <= buf_valid & mounted;
      if (wr_ok)    dirty   <= 1'b1;
      case (st)
        IDLE: begin
          if (en && first && is_hcrc && mounted && !dirty) begin
            st         <= RD_REQ;
            req_drive  <= drive;
            sd.rsector <= lba;
            sd.rstart  <= NDRIVES'(1) << drive;
          end else if (first && is_g3 && dirty) begin
            st        <= WR_REQ;
            sd.wstart <= NDRIVES'(1) << req_drive;
          end
        end
        RD_REQ: begin
          if (!motor || sd.sd_busy) begin
            st        <= motor ? RD_WAIT : IDLE;
            sd.rstart <= '0;
          end
        end
        RD_WAIT: begin
          if (!motor) st <= IDLE;
          else if (sd.sd_done) begin
            buf_valid <= 1'b1;
            st        <= IDLE;
          end
        end
        WR_REQ: begin
          if (sd.sd_busy) begin
            st        <= WR_WAIT;
            sd.wstart <= '0;
          end
        end
        WR_WAIT: begin
          if (sd.sd_done) begin
            dirty <= 1'b0;
            st    <= IDLE;
          end
        end
        default: st <= IDLE;
      endcase
      // Every header crc of a mounted drive invalidates the buffer, even when
      // a write-back keeps the read from starting.
      if (en && first && is_hcrc && mounted) buf_valid <= 1'b0;
    end
  end

  always_ff @(posedge pin_25mhz_ck) begin
    if (wr_ok) mem[widx] <= data_in;
    if (sd.outen) begin
      if (sd.outaddr[0]) mem[baddr][15:8] <= sd.inbyte;
      else               mem[baddr][7:0]  <= sd.inbyte;
    end
  end

  always_ff @(posedge pin_25mhz_ck or negedge ppu_vm_init_n) begin
    if (!ppu_vm_init_n) sd.outbyte <= '0;
    else sd.outbyte <= sd.outaddr[0] ? mem[baddr][15:8] : mem[baddr][7:0];
  end

  always_comb begin
    data_out = GAP_W;
    if (en) begin
      if (is_hsync || is_dsync) data_out = 16'hA1A1;
      else if (is_hw1)          data_out = {1'b0, 7'(cur_track), 7'd0, head};
      else if (is_hw2)          data_out = {4'd0, 4'(sector + 1'b1), 8'd2};
      else if (is_data && data_ok && mounted)
        data_out = {mem[widx][7:0], mem[widx][15:8]};
    end
  end

  assign sync   = en & (is_hsync | is_dsync);
  assign crc_ok = en & (is_hcrc | (is_dcrc & data_ok & mounted));
  assign ind    = en & (sector == '0) & (slot < SLW'(4));
  assign valid  = en & (32'(presc) >= 32'd10) & (32'(presc) <= 32'd899);
  assign tr0    = en & (cur_track == '0);
endmodule

// File: tb/tb_fdd_track_emu.sv
// Directed bench for fdd_track_emu with a short prescaler and 16-word sectors;
// bench time is counted in clocks since the last rotation restart.
module tb_fdd_track_emu;
  localparam int CD = 16;
  localparam int ND = 4;
  localparam int W  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [1:0]  drive;
  logic        motor, step, dir, head, write;
  logic [15:0] data_in, data_out;
  logic [3:0]  mount_dsk;
  logic        valid, sync, crc_ok, ind, tr0, rdy;
`ifdef FDD_WPROT_EN
  logic [3:0]  wprot;
  logic        wp;
`endif

  fdd_track_emu_if #(.NDRIVES(ND), .WORDS(W)) sd();

  fdd_track_emu #(.CLK_DIV(CD), .NDRIVES(ND), .WORDS(W)) dut (
    .pin_25mhz_ck(clk), .ppu_vm_init_n(rst_n), .drive(drive), .motor(motor),
    .step(step), .dir(dir), .head(head), .write(write), .data_in(data_in),
    .mount_dsk(mount_dsk), .data_out(data_out), .valid(valid), .sync(sync),
    .crc_ok(crc_ok), .ind(ind), .tr0(tr0), .rdy(rdy),
`ifdef FDD_WPROT_EN
    .wprot(wprot), .wp(wp),
`endif
    .sd(sd)
  );

  int tests = 0;
  int fails = 0;
  int g = 0;
  bit rs_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    g++;
    if (sd.rstart != '0) rs_seen = 1'b1;
  endtask

  task automatic goto(input int s, input int off);
    while (g < s * CD + off) tick();
  endtask

  task automatic restart_rot();
    motor = 1'b0;
    tick();
    motor = 1'b1;
    g = 0;
  endtask

  task automatic step_pulse();
    step = 1'b1;
    repeat (3) tick();
    step = 1'b0;
    repeat (3) tick();
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    drive = '0; motor = 1'b1; step = 1'b0; dir = 1'b1; head = 1'b0;
    write = 1'b0; data_in = '0; mount_dsk = 4'b0001;
    sd.sd_busy = 1'b0; sd.sd_done = 1'b0; sd.outen = 1'b0;
    sd.outaddr = '0; sd.inbyte = '0;
`ifdef FDD_WPROT_EN
    wprot = '0;
`endif
    repeat (3) tick();
    chk("rst_data_out", data_out, 16'h4E4E);
    chk("rst_rdy", rdy, 0);
    chk("rst_ind", ind, 0);
    chk("rst_tr0", tr0, 0);
    chk("rst_rstart", sd.rstart, 0);
    chk("rst_outbyte", sd.outbyte, 0);

    // sector 0 of track 0, drive 0
    rst_n = 1'b1; g = 0;
    tick();
    chk("rdy_after_rst", rdy, 1);
    chk("ind_slot0", ind, 1);
    chk("tr0_track0", tr0, 1);
    goto(3, 8);  chk("ind_slot3", ind, 1);
    goto(4, 8);  chk("ind_slot4", ind, 0);
    goto(5, 9);  chk("valid_presc9", valid, 0);
    goto(5, 10); chk("valid_presc10", valid, 1);
    goto(23, 8); chk("sync_slot23", sync, 0);
    goto(24, 8); chk("sync_slot24", sync, 1);
    goto(25, 8); chk("hdr_w1_t0", data_out, 16'h0000);
    goto(26, 8); chk("hdr_w2_s0", data_out, 16'h0102);
    goto(27, 4);
    chk("rstart_s0", sd.rstart, 4'b0001);
    chk("rsector_s0", sd.rsector, 0);
    chk("hcrc_s0", crc_ok, 1);
    sd.sd_busy = 1'b1; tick(); sd.sd_busy = 1'b0;
    chk("rstart_drop", sd.rstart, 0);
    for (int a = 0; a < 2 * W; a++) begin
      sd.outen = 1'b1; sd.outaddr = 5'(a); sd.inbyte = 8'(a * 3 + 1);
      tick();
    end
    sd.outen = 1'b0;
    sd.sd_done = 1'b1; tick(); sd.sd_done = 1'b0;
    goto(47, 8); chk("dsync", sync, 1);
    goto(50, 8); chk("data_w2", data_out, 16'h0D10);
    goto(55, 2);
    write = 1'b1; data_in = 16'hA55A; tick(); write = 1'b0;
    goto(55, 8); chk("data_w7_written", data_out, 16'h5AA5);
    goto(64, 8); chk("dcrc_ok", crc_ok, 1);
    goto(65, 4);
    chk("wstart_g3", sd.wstart, 4'b0001);
    chk("wr_rsector", sd.rsector, 0);
    sd.sd_busy = 1'b1; tick(); sd.sd_busy = 1'b0;
    chk("wstart_drop", sd.wstart, 0);
    sd.outaddr = 5'd14; tick(); chk("sd_byte14", sd.outbyte, 8'h5A);
    sd.outaddr = 5'd15; tick(); chk("sd_byte15", sd.outbyte, 8'hA5);
    sd.sd_done = 1'b1; tick(); sd.sd_done = 1'b0;
    goto(94, 4);
    chk("rstart_s1", sd.rstart, 4'b0001);
    chk("rsector_s1", sd.rsector, 1);

    // track 5, head 1, sector 3
    dir = 1'b1;
    repeat (5) step_pulse();
    chk("tr0_track5", tr0, 0);
    head = 1'b1; mount_dsk = 4'b0000;
    restart_rot();
    goto(202, 8); chk("ind_s3", ind, 0);
    goto(226, 8); chk("hdr_w1_t5h1", data_out, 16'h0501);
    goto(227, 8); chk("hdr_w2_s3", data_out, 16'h0402);
    mount_dsk = 4'b0001;
    goto(228, 4);
    chk("rstart_s3", sd.rstart, 4'b0001);
    chk("rsector_113", sd.rsector, 113);

    // clamp at both track limits
    repeat (90) step_pulse();
    restart_rot();
    goto(25, 8); chk("hdr_t79", data_out, 16'h4F01);
    chk("tr0_t79", tr0, 0);
    head = 1'b0; dir = 1'b0;
    repeat (90) step_pulse();
    chk("tr0_back0", tr0, 1);
    restart_rot();
    goto(25, 8); chk("hdr_t0", data_out, 16'h0000);
    goto(27, 4); chk("rsector_t0", sd.rsector, 0);

    // read never completes: data field invalid, write ignored
    sd.sd_busy = 1'b1; tick(); sd.sd_busy = 1'b0;
    goto(50, 2);
    write = 1'b1; data_in = 16'h1234; tick(); write = 1'b0;
    goto(50, 8); chk("data_nobuf", data_out, 16'h4E4E);
    goto(64, 8); chk("dcrc_nobuf", crc_ok, 0);
    goto(65, 4); chk("wstart_nobuf", sd.wstart, 0);

    // valid buffer but disk unmounted for sector 1
    restart_rot();
    goto(27, 4);
    sd.sd_busy = 1'b1; tick(); sd.sd_busy = 1'b0;
    sd.sd_done = 1'b1; tick(); sd.sd_done = 1'b0;
    goto(67, 0);
    mount_dsk = 4'b0000; rs_seen = 1'b0;
    goto(117, 8); chk("data_unmounted", data_out, 16'h4E4E);
    goto(131, 8); chk("dcrc_unmounted", crc_ok, 0);
    goto(134, 0); chk("rstart_unmounted", rs_seen, 0);

`ifdef FDD_WPROT_EN
    mount_dsk = 4'b0001; wprot = 4'b0001;
    restart_rot();
    chk("wp_on", wp, 1);
    goto(27, 4);
    sd.sd_busy = 1'b1; tick(); sd.sd_busy = 1'b0;
    sd.sd_done = 1'b1; tick(); sd.sd_done = 1'b0;
    goto(51, 2);
    write = 1'b1; data_in = 16'hFFFF; tick(); write = 1'b0;
    goto(51, 8); chk("wp_data_kept", data_out, 16'h1316);
    goto(65, 4); chk("wp_wstart", sd.wstart, 0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/fdd_track_emu.md
Name: fdd_track_emu

Overview:
- Parametrised floppy-track emulator for the PPU disk controller path; successor to the fixed 10-sector, 80-track, read-only emulator.
- Generates rotational timing, index/sync/crc_ok strobes and the raw word stream for one track of the selected drive.
- Fetches sectors from SD via per-drive request lines and buffers them.
- Adds write-back: writes into a sector's data field are flushed to SD after that sector passes.
- Keeps a track register per drive, clamps at the last track, and works in a single clock domain.

Parameters:
- CLK_DIV, 1600: clocks per word slot (64 us at 25 MHz).
- NDRIVES, 4: drives; one rstart/wstart bit and one track register each.
- TRACKS, 80: tracks per side; track register clamps at 0 and TRACKS-1.
- HEADS, 2: sides.
- SECTORS, 10: sectors per track.
- WORDS, 256: 16-bit words per sector (SD byte buffer = 2*WORDS).
- GAP1, 24: leading gap slots per sector.
- GAP2, 19: header-to-data gap slots.
- GAP3, 2: trailing gap slots per sector.
- GAP4, 54: end-of-track gap slots after the last sector.

Ports:
- pin_25mhz_ck  in  1  system clock
- ppu_vm_init_n  in  1  async active-low reset
- drive  in  log2(NDRIVES)  selected drive
- motor  in  1  spindle on
- step  in  1  step pulse from PPU (asynchronous, synchronised internally)
- dir  in  1  1 = step in (track+1)
- head  in  1  side select
- write  in  1  write strobe for data_in in the current data slot
- data_in  in  16  word to write
- mount_dsk  in  NDRIVES  image present per drive
- data_out  out  16  raw track word
- valid, sync, crc_ok, ind, tr0, rdy  out  1  status strobes
- rstart, wstart  out  NDRIVES  SD read/write requests
- rsector  out  32  SD LBA
- sd_busy, sd_done  in  1  SD controller busy level / completion pulse
- outen  in  1  SD-side byte write
- outaddr  in  log2(2*WORDS)  SD-side byte address
- inbyte  in  8  SD-side write byte
- outbyte  out  8  SD-side read byte

Behaviour:
- Reset values: all outputs 0, except data_out=16'h4E4E.
  - Internal state: slot=0, sector=0, all track registers=0, buf_valid=0, dirty=0, request FSM in IDLE.
  - rdy = 1 one clock after reset release.
- Rotation:
  - Prescaler counts 0..CLK_DIV-1; the slot advances on wrap.
  - Sector slots S = GAP1+4+GAP2+1+WORDS+1+GAP3.
  - After the last sector, GAP4 gap slots run, then sector 0 slot 0.
- Rotation restart: !motor, a step edge, or a head/drive change resets slot, sector and prescaler to 0 in the same clock.
- Sector layout (slot k within a sector):
  - 0..GAP1-1: gap.
  - GAP1: sync. GAP1+1: {1'b0,track[6:0],7'd0,head}. GAP1+2: {4'd0,sector+1,8'd2}. GAP1+3: crc_ok.
  - Then GAP2 gap slots, data sync, WORDS data slots (byte-swapped buffer word), data crc_ok, GAP3 gap slots.
  - Gap words are 16'h4E4E.
  - If mount_dsk[drive]=0, or the data field starts with buf_valid=0, data slots output 4E4E and crc_ok is suppressed.
- Strobes (all gated by motor):
  - sync: sync slots.
  - crc_ok: crc slots.
  - ind: slots 0..3 of sector 0.
  - valid: prescaler in 10..899.
  - tr0: track[drive]==0.
- Stepping:
  - step passes through a 2-FF synchroniser; the rising edge updates track[drive].
  - dir=1: saturate at TRACKS-1. dir=0: saturate at 0.
- LBA: rsector = (track*HEADS+head)*SECTORS+sector, zero-extended to 32 bits, latched at request start.
- Request FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
  - At header crc slot, if mounted: IDLE -> RD_REQ, buf_valid<=0.
  - RD_REQ: rstart[drive]=1 until sd_busy=1, then RD_WAIT.
  - RD_WAIT: on sd_done, buf_valid<=1, return to IDLE.
  - Data-slot write with buf_valid=1: store data_in at the word index and set dirty.
  - At the first GAP3 slot, if dirty: WR_REQ with the latched LBA; wstart until sd_busy, then WR_WAIT.
  - WR_WAIT: on sd_done, clear dirty, return to IDLE.
- Boundary rules:
  - A pending write is never cancelled by motor off, step or drive change; the read for the next sector is skipped while the write is in progress.
  - Read aborts (return to IDLE) on motor off.
  - A write before the first data slot, or with buf_valid=0, is ignored.
  - SD-side port uses byte address a -> word a>>1; low byte = even address.

Optional Feature:
- FDD_WPROT_EN, defined: adds input wprot[NDRIVES] and output wp = wprot[drive]&motor. Writes to protected drives are ignored, dirty is never set, and wstart stays 0.
- FDD_WPROT_EN, undefined: no wprot port, wp is absent, and all mounted drives are writable.

Test Plan:
- Reset, motor=1, drive0 mounted -> ind high in sector-0 slots 0..3; sync at slot 24; rstart=4'b0001 at slot 27 with rsector=0.
- track=5, head=1, sector 3 -> rsector=(5*2+1)*10+3=113; word at slot 25 = 16'h0501.
- 90 step pulses with dir=1 -> track saturates at 79; 90 with dir=0 -> 0, tr0=1.
- sd_done, then write of 16'hA55A at data index 7 -> wstart=0001 at first GAP3 slot; SD side reads bytes 14/15 = 5A/A5.
- mount_dsk=0 -> data slots output 4E4E, crc_ok suppressed in the data crc slot, rstart never asserted.
- FDD_WPROT_EN with wprot[0]=1 -> write ignored, wstart stays 0, wp=1.
